mont_final_sub: RTL and testbench

MONT_FINAL_SUB -- requirements
Module: mont_final_sub

---
 rtl/mont_final_sub.sv | 139 +++++++++++++
 tb/tb_mont_final_sub.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mont_final_sub.sv
// Montgomery final conditional subtraction: result = (T >= M) ? T - M : T.
// The (WIDTH+1)-bit subtraction runs CW bits per cycle over CHUNKS cycles,
// then the final borrow selects between T and T - M.
//
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   start   begin one reduction (sampled only while idle)
//   in_t    unreduced sum T, WIDTH+1 bits
//   in_m    modulus M, WIDTH bits
//   busy    registered, high while a reduction is in progress
//   done    registered one-cycle pulse, result valid
//   result  reduced value, held until the next completion
module mont_final_sub #(
    parameter int WIDTH  = 1027,
    parameter int CHUNKS = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH:0]   in_t,
    input  logic [WIDTH-1:0] in_m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH + 1) / CHUNKS;
    localparam int KW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        SEL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   t_q, t_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [WIDTH:0]   diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic [KW-1:0]    k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [CW-1:0] t_chunk;
    logic [CW-1:0] m_chunk;
    logic [CW:0]   d_chunk;

    // The top bit of the difference only matters through the borrow.
    logic unused_diff_msb;
    assign unused_diff_msb = diff_q[WIDTH];

    // One chunk of the ripple subtraction; bit CW of d_chunk is borrow-out.
    always_comb begin
        t_chunk = t_q[int'(k_q)*CW +: CW];
        m_chunk = m_q[int'(k_q)*CW +: CW];
        d_chunk = {1'b0, t_chunk} - {1'b0, m_chunk}
                - {{CW{1'b0}}, borrow_q};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            t_q      <= '0;
            m_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            k_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            m_q      <= m_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            k_q      <= k_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = SUB;
            SUB:  if (k_q == K_LAST) state_d = SEL;
            SEL:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        t_d      = t_q;
        m_d      = m_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        k_d      = k_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    t_d      = in_t;
                    m_d      = {1'b0, in_m};
                    k_d      = '0;
                    borrow_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            SUB: begin
                diff_d[int'(k_q)*CW +: CW] = d_chunk[CW-1:0];
                borrow_d = d_chunk[CW];
                k_d      = k_q + 1'b1;
            end
            SEL: begin
                // Final borrow set means T < M, so T is already reduced.
                result_d = borrow_q ? t_q[WIDTH-1:0]
                                    : diff_q[WIDTH-1:0];
                done_d   = 1'b1;
                busy_d   = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mont_final_sub.sv
// Self-checking bench for mont_final_sub: directed vector table,
// back-to-back, reset-abort and randomized checks against T-M arithmetic.
module tb_mont_final_sub;

    localparam int W      = 1027;
    localparam int CHUNKS = 4;
    localparam int PERIOD = CHUNKS + 2;

    typedef logic [W:0]   wide_t;
    typedef logic [W-1:0] narrow_t;

    typedef struct {
        wide_t   t;
        narrow_t m;
        narrow_t e;
    } vec_t;

    logic    clk;
    logic    resetn;
    logic    start;
    wide_t   in_t;
    narrow_t in_m;
    logic    busy;
    logic    done;
    narrow_t result;

    int checks   = 0;
    int failures = 0;

    mont_final_sub #(.WIDTH(W), .CHUNKS(CHUNKS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .in_t   (in_t),
        .in_m   (in_m),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input wide_t act,
                       input wide_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual(lo128)=%h required(lo128)=%h",
                     name, act[127:0], exp[127:0]);
        end
    endtask

    function automatic narrow_t ref_model(input wide_t t,
                                          input narrow_t m);
        wide_t mm;
        wide_t r;
        mm = {1'b0, m};
        r  = (t >= mm) ? t - mm : t;
        return r[W-1:0];
    endfunction

    function automatic wide_t rnd_wide();
        logic [1055:0] r;
        for (int i = 0; i < 33; i++) r[i*32 +: 32] = $urandom;
        return r[W:0];
    endfunction

    // Caller is positioned at a negedge; start is sampled at the next edge.
    task automatic do_op(input wide_t t, input narrow_t m,
                         input narrow_t exp, input string tag);
        int    cyc;
        wide_t g;
        in_t  = t;
        in_m  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!done && cyc < 20) begin
            chk({tag, " busy"}, wide_t'(busy), wide_t'(1));
            g     = rnd_wide();
            in_t  = g;
            g     = rnd_wide();
            in_m  = g[W-1:0];
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, " latency"}, wide_t'(cyc), wide_t'(CHUNKS + 1));
        chk({tag, " done"}, wide_t'(done), wide_t'(1));
        chk({tag, " busy@done"}, wide_t'(busy), wide_t'(0));
        chk({tag, " result"}, wide_t'(result), wide_t'(exp));
        @(negedge clk);
        chk({tag, " done_pulse"}, wide_t'(done), wide_t'(0));
        chk({tag, " idle"}, wide_t'(busy), wide_t'(0));
        chk({tag, " hold"}, wide_t'(result), wide_t'(exp));
    endtask

    vec_t    vecs[8];
    wide_t   one;
    wide_t   tt;
    wide_t   rr;
    narrow_t mm;
    wide_t   bt_t[3];
    narrow_t bt_m[3];
    narrow_t bt_e[3];

    initial begin
        one = wide_t'(1);
        vecs[0] = '{t: wide_t'(5), m: narrow_t'(7), e: narrow_t'(5)};
        vecs[1] = '{t: wide_t'(7), m: narrow_t'(7), e: narrow_t'(0)};
        vecs[2] = '{t: wide_t'(8), m: narrow_t'(7), e: narrow_t'(1)};
        tt = (one << 1027) - 2;
        vecs[3] = '{t: (one << 1028) - 3, m: '1, e: tt[W-1:0]};
        tt = (one << 257) - 1;
        vecs[4] = '{t: one << 257, m: narrow_t'(1), e: tt[W-1:0]};
        tt = (one << 1000) + 12345;
        vecs[5] = '{t: tt - 1, m: tt[W-1:0], e: narrow_t'(tt - 1)};
        vecs[6] = '{t: wide_t'(100), m: narrow_t'(7), e: narrow_t'(93)};
        vecs[7] = '{t: {1'b0, {W{1'b1}}}, m: '1, e: narrow_t'(0)};

        resetn = 1'b0;
        start  = 1'b0;
        in_t   = '0;
        in_m   = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", wide_t'(busy), wide_t'(0));
        chk("reset done", wide_t'(done), wide_t'(0));
        chk("reset result", wide_t'(result), wide_t'(0));

        // First start is presented together with reset release.
        resetn = 1'b1;
        for (int i = 0; i < 8; i++)
            do_op(vecs[i].t, vecs[i].m, vecs[i].e,
                  $sformatf("vec%0d", i));

        // start held high: accepts every PERIOD edges, garbage between.
        for (int k = 0; k < 3; k++) begin
            rr      = rnd_wide();
            bt_m[k] = rr[W-1:0] | narrow_t'(1);
            rr      = rnd_wide();
            bt_t[k] = rr % {bt_m[k], 1'b0};
            bt_e[k] = ref_model(bt_t[k], bt_m[k]);
        end
        begin
            int n;
            int e;
            int nd;
            logic exp_done;
            logic exp_busy;
            n  = 0;
            nd = 0;
            for (int c = 0; c < 22; c++) begin
                if (c > 0) begin
                    e = c - 1;
                    exp_done = (e % PERIOD == PERIOD - 1) && (e < 3 * PERIOD);
                    exp_busy = (e % PERIOD < PERIOD - 1) && (e < 3 * PERIOD);
                    chk($sformatf("b2b done e%0d", e),
                        wide_t'(done), wide_t'(exp_done));
                    chk($sformatf("b2b busy e%0d", e),
                        wide_t'(busy), wide_t'(exp_busy));
                    if (done) nd++;
                    if (exp_done && n < 3) begin
                        chk($sformatf("b2b result%0d", n),
                            wide_t'(result), wide_t'(bt_e[n]));
                        n++;
                    end
                end
                start = (c <= 2 * PERIOD);
                if (c % PERIOD == 0 && c <= 2 * PERIOD) begin
                    in_t = bt_t[c / PERIOD];
                    in_m = bt_m[c / PERIOD];
                end else begin
                    in_t = rnd_wide();
                    rr   = rnd_wide();
                    in_m = rr[W-1:0];
                end
                @(negedge clk);
            end
            start = 1'b0;
            chk("b2b done count", wide_t'(nd), wide_t'(3));
        end

        // Reset asserted across E3 aborts the operation.
        in_t  = wide_t'(12345);
        in_m  = narrow_t'(99);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("abort busy", wide_t'(busy), wide_t'(0));
        chk("abort done", wide_t'(done), wide_t'(0));
        chk("abort result", wide_t'(result), wide_t'(0));
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort no done", wide_t'(done), wide_t'(0));
        end
        chk("abort result held", wide_t'(result), wide_t'(0));
        do_op(wide_t'(1000), narrow_t'(999), narrow_t'(1), "after abort");

        // Randomized operands against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            rr = rnd_wide();
            mm = rr[W-1:0] | narrow_t'(1);
            if (i % 8 == 0) mm = mm >> $urandom_range(0, 1000);
            if (mm == '0) mm = narrow_t'(3);
            rr = rnd_wide();
            unique case (i % 4)
                0: tt = rr % {mm, 1'b0};
                1: tt = {1'b0, mm} - wide_t'($urandom_range(0, 2));
                2: tt = {1'b0, mm} + wide_t'($urandom_range(0, 2));
                default: tt = rr;
            endcase
            do_op(tt, mm, ref_model(tt, mm), $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
